// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbitration bundle: requester side (master) and arbiter side (slave).
interface cdb_arbiter_if #(
    parameter int REQUESTERS = 4
);
    logic [REQUESTERS-1:0] request;
    logic                  flush;
    logic [7:0]            select_0;
    logic [7:0]            select_1;
    logic [REQUESTERS-1:0] grant;
    logic                  busy;

    modport master (
        output request, flush,
        input  select_0, select_1, grant, busy
    );

    modport slave (
        input  request, flush,
        output select_0, select_1, grant, busy
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Two-bus common-data-bus arbiter: aged requesters first, then round-robin,
// with one-cycle registered grants and a mandatory gap between transfers.
module cdb_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int MAX_WAIT   = 7
) (
    input  logic         clock,
    input  logic         reset,
    cdb_arbiter_if.slave bus
);
    localparam int IDX_W  = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1;
    localparam int CNT_W  = $clog2(REQUESTERS + 1);
    localparam int WAIT_W = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [IDX_W:0]    REQ_COUNT = (IDX_W + 1)'(REQUESTERS);
    localparam logic [CNT_W-1:0]  BUS_COUNT = CNT_W'(2);
    localparam logic [7:0]        IDLE_SEL  = 8'hFF;

    logic [REQUESTERS-1:0] eligible_s;
    logic [REQUESTERS-1:0] aged_s;
    logic [REQUESTERS-1:0] chosen_s;
    logic [REQUESTERS-1:0] grant_r;
    logic [IDX_W-1:0]      rr_ptr_r;
    logic [IDX_W-1:0]      rr_next_s;
    logic [IDX_W-1:0]      rr_last_s;
    logic [IDX_W-1:0]      idx_s;
    logic [IDX_W:0]        sum_s;
    logic [IDX_W-1:0]      win0_s;
    logic [IDX_W-1:0]      win1_s;
    logic                  win0_v_s;
    logic                  win1_v_s;
    logic                  rr_hit_s;
    logic [CNT_W-1:0]      elig_cnt_s;
    logic [WAIT_W-1:0]     wait_r      [REQUESTERS];
    logic [WAIT_W-1:0]     wait_next_s [REQUESTERS];
    logic [7:0]            select_0_r;
    logic [7:0]            select_1_r;
    logic                  busy_r;

    // Winner selection: aged requesters by index, then round-robin from rr_ptr.
    always_comb begin
        eligible_s = bus.request & ~grant_r;
        aged_s     = {REQUESTERS{1'b0}};
        chosen_s   = {REQUESTERS{1'b0}};
        win0_s     = {IDX_W{1'b0}};
        win1_s     = {IDX_W{1'b0}};
        win0_v_s   = 1'b0;
        win1_v_s   = 1'b0;
        rr_hit_s   = 1'b0;
        rr_last_s  = rr_ptr_r;
        rr_next_s  = rr_ptr_r;
        sum_s      = {(IDX_W + 1){1'b0}};
        idx_s      = {IDX_W{1'b0}};
        elig_cnt_s = {CNT_W{1'b0}};
        for (int i = 0; i < REQUESTERS; i++) begin
            aged_s[i]  = eligible_s[i] && (wait_r[i] == WAIT_MAX);
            elig_cnt_s = elig_cnt_s + CNT_W'(eligible_s[i]);
        end
        for (int i = 0; i < REQUESTERS; i++) begin
            if (aged_s[i] && !win1_v_s) begin
                chosen_s[i] = 1'b1;
                if (win0_v_s) begin
                    win1_v_s = 1'b1;
                    win1_s   = IDX_W'(i);
                end else begin
                    win0_v_s = 1'b1;
                    win0_s   = IDX_W'(i);
                end
            end else begin
                chosen_s[i] = chosen_s[i];
            end
        end
        for (int k = 0; k < REQUESTERS; k++) begin
            sum_s = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
            idx_s = (sum_s >= REQ_COUNT) ? IDX_W'(sum_s - REQ_COUNT) : IDX_W'(sum_s);
            if (eligible_s[idx_s] && !chosen_s[idx_s] && !win1_v_s) begin
                chosen_s[idx_s] = 1'b1;
                rr_hit_s        = 1'b1;
                rr_last_s       = idx_s;
                if (win0_v_s) begin
                    win1_v_s = 1'b1;
                    win1_s   = idx_s;
                end else begin
                    win0_v_s = 1'b1;
                    win0_s   = idx_s;
                end
            end else begin
                chosen_s[idx_s] = chosen_s[idx_s];
            end
        end
        sum_s = {1'b0, rr_last_s} + {{IDX_W{1'b0}}, 1'b1};
        if (rr_hit_s) begin
            rr_next_s = (sum_s >= REQ_COUNT) ? {IDX_W{1'b0}} : IDX_W'(sum_s);
        end else begin
            rr_next_s = rr_ptr_r;
        end
    end

    // Wait counters: count losing eligible cycles, saturate at the aging threshold.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            wait_next_s[i] = wait_r[i];
            if (chosen_s[i] || !bus.request[i]) begin
                wait_next_s[i] = {WAIT_W{1'b0}};
            end else if (eligible_s[i] && (wait_r[i] != WAIT_MAX)) begin
                wait_next_s[i] = wait_r[i] + WAIT_W'(1);
            end else begin
                wait_next_s[i] = wait_r[i];
            end
        end
    end

    // Decision registers; flush idles the buses but keeps the round-robin position.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            select_0_r <= IDLE_SEL;
            select_1_r <= IDLE_SEL;
            grant_r    <= {REQUESTERS{1'b0}};
            busy_r     <= 1'b0;
            rr_ptr_r   <= {IDX_W{1'b0}};
            for (int i = 0; i < REQUESTERS; i++) begin
                wait_r[i] <= {WAIT_W{1'b0}};
            end
        end else if (bus.flush) begin
            select_0_r <= IDLE_SEL;
            select_1_r <= IDLE_SEL;
            grant_r    <= {REQUESTERS{1'b0}};
            busy_r     <= 1'b0;
            rr_ptr_r   <= rr_ptr_r;
            for (int i = 0; i < REQUESTERS; i++) begin
                wait_r[i] <= {WAIT_W{1'b0}};
            end
        end else begin
            select_0_r <= win0_v_s ? {{(8 - IDX_W){1'b0}}, win0_s} : IDLE_SEL;
            select_1_r <= win1_v_s ? {{(8 - IDX_W){1'b0}}, win1_s} : IDLE_SEL;
            grant_r    <= chosen_s;
            busy_r     <= (elig_cnt_s > BUS_COUNT);
            rr_ptr_r   <= rr_next_s;
            for (int i = 0; i < REQUESTERS; i++) begin
                wait_r[i] <= wait_next_s[i];
            end
        end
    end

    assign bus.select_0 = select_0_r;
    assign bus.select_1 = select_1_r;
    assign bus.grant    = grant_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a 4-requester default instance and an
// 8-requester instance with a short aging threshold, both against a queue-based model.
module tb_cdb_arbiter;
    typedef struct packed {
        logic [7:0] sel0;
        logic [7:0] sel1;
        logic [7:0] grant;
        logic       busy;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cdb_arbiter_if #(.REQUESTERS(4)) bus_a ();
    cdb_arbiter_if #(.REQUESTERS(8)) bus_b ();

    cdb_arbiter #(.REQUESTERS(4), .MAX_WAIT(7)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    cdb_arbiter #(.REQUESTERS(8), .MAX_WAIT(2)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    int tests = 0;
    int fails = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t mon_a;
    exp_t mon_b;

    int         m_n  [2] = '{4, 8};
    int         m_mw [2] = '{7, 2};
    int         m_rr [2];
    int         m_wait [2][8];
    logic [7:0] m_grant [2];

    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            m_rr[u]    = 0;
            m_grant[u] = 8'h00;
            for (int i = 0; i < 8; i++) m_wait[u][i] = 0;
        end
    endfunction

    // Arbitration rules stated directly: eligible set, aged list, round-robin sweep.
    function automatic exp_t model_step(int u, logic [7:0] req, bit fl);
        exp_t e;
        bit   elig   [8];
        bit   picked [8];
        int   win [$];
        int   cnt  = 0;
        int   last = -1;
        int   idx;
        e.sel0  = 8'hFF;
        e.sel1  = 8'hFF;
        e.grant = 8'h00;
        e.busy  = 1'b0;
        if (fl) begin
            for (int i = 0; i < 8; i++) m_wait[u][i] = 0;
            m_grant[u] = 8'h00;
            return e;
        end
        for (int i = 0; i < m_n[u]; i++) begin
            elig[i]   = req[i] && !m_grant[u][i];
            picked[i] = 1'b0;
            if (elig[i]) cnt++;
        end
        for (int i = 0; i < m_n[u]; i++) begin
            if (elig[i] && m_wait[u][i] == m_mw[u] && win.size() < 2) begin
                win.push_back(i);
                picked[i] = 1'b1;
            end
        end
        for (int k = 0; k < m_n[u]; k++) begin
            idx = (m_rr[u] + k) % m_n[u];
            if (elig[idx] && !picked[idx] && win.size() < 2) begin
                win.push_back(idx);
                picked[idx] = 1'b1;
                last = idx;
            end
        end
        if (last >= 0) m_rr[u] = (last + 1) % m_n[u];
        if (win.size() > 0) e.sel0 = 8'(win[0]);
        if (win.size() > 1) e.sel1 = 8'(win[1]);
        foreach (win[j]) e.grant[win[j]] = 1'b1;
        e.busy = (cnt > 2);
        for (int i = 0; i < m_n[u]; i++) begin
            if (picked[i] || !req[i]) m_wait[u][i] = 0;
            else if (elig[i] && m_wait[u][i] < m_mw[u]) m_wait[u][i]++;
        end
        m_grant[u] = e.grant;
        return e;
    endfunction

    task automatic drive(logic [3:0] ra, logic [7:0] rb, bit fl);
        @(negedge clock);
        bus_a.request = ra;
        bus_b.request = rb;
        bus_a.flush   = fl;
        bus_b.flush   = fl;
        sb_a.push_back(model_step(0, {4'b0000, ra}, fl));
        sb_b.push_back(model_step(1, rb, fl));
    endtask

    task automatic expect_a(string tag, logic [7:0] s0, logic [7:0] s1, logic [3:0] g, bit b);
        @(posedge clock);
        #1;
        check({tag, ".select_0"}, bus_a.select_0, s0);
        check({tag, ".select_1"}, bus_a.select_1, s1);
        check({tag, ".grant"}, {4'b0000, bus_a.grant}, {4'b0000, g});
        check({tag, ".busy"}, {7'b0000000, bus_a.busy}, {7'b0000000, b});
    endtask

    task automatic check_idle(string tag);
        check({tag, ".a.select_0"}, bus_a.select_0, 8'hFF);
        check({tag, ".a.select_1"}, bus_a.select_1, 8'hFF);
        check({tag, ".a.grant"}, {4'b0000, bus_a.grant}, 8'h00);
        check({tag, ".a.busy"}, {7'b0000000, bus_a.busy}, 8'h00);
        check({tag, ".b.select_0"}, bus_b.select_0, 8'hFF);
        check({tag, ".b.grant"}, bus_b.grant, 8'h00);
    endtask

    // Monitor: every cycle with a pending expectation is compared field by field.
    always @(posedge clock) begin
        #1;
        if (sb_a.size() > 0) begin
            mon_a = sb_a.pop_front();
            check("a.select_0", bus_a.select_0, mon_a.sel0);
            check("a.select_1", bus_a.select_1, mon_a.sel1);
            check("a.grant", {4'b0000, bus_a.grant}, mon_a.grant);
            check("a.busy", {7'b0000000, bus_a.busy}, {7'b0000000, mon_a.busy});
        end
        if (sb_b.size() > 0) begin
            mon_b = sb_b.pop_front();
            check("b.select_0", bus_b.select_0, mon_b.sel0);
            check("b.select_1", bus_b.select_1, mon_b.sel1);
            check("b.grant", bus_b.grant, mon_b.grant);
            check("b.busy", {7'b0000000, bus_b.busy}, {7'b0000000, mon_b.busy});
        end
    end

    initial begin
        logic [3:0] ra;
        logic [7:0] rb;
        bit         fl;
        reset         = 1'b1;
        bus_a.request = 4'b0000;
        bus_b.request = 8'h00;
        bus_a.flush   = 1'b0;
        bus_b.flush   = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_idle("reset");
        @(negedge clock);
        reset = 1'b0;

        // Single held requester: grant, gap, grant.
        drive(4'b0001, 8'h00, 1'b0); expect_a("single1", 8'h00, 8'hFF, 4'b0001, 1'b0);
        drive(4'b0001, 8'h00, 1'b0); expect_a("gap",     8'hFF, 8'hFF, 4'b0000, 1'b0);
        drive(4'b0001, 8'h00, 1'b0); expect_a("single2", 8'h00, 8'hFF, 4'b0001, 1'b0);
        drive(4'b0000, 8'h00, 1'b0);

        // Bring rr_ptr to 0, then all four held.
        drive(4'b1000, 8'h00, 1'b0);
        drive(4'b0000, 8'h00, 1'b0);
        drive(4'b1111, 8'h00, 1'b0); expect_a("all_c1", 8'h00, 8'h01, 4'b0011, 1'b1);
        drive(4'b1111, 8'h00, 1'b0); expect_a("all_c2", 8'h02, 8'h03, 4'b1100, 1'b0);
        drive(4'b1111, 8'h00, 1'b0); expect_a("all_c3", 8'h00, 8'h01, 4'b0011, 1'b0);
        drive(4'b0000, 8'h00, 1'b0);

        // rr_ptr = 3 with 1110: wrap-around, pointer lands on 2.
        drive(4'b0100, 8'h00, 1'b0);
        drive(4'b0000, 8'h00, 1'b0);
        drive(4'b1110, 8'h00, 1'b0); expect_a("wrap",    8'h03, 8'h01, 4'b1010, 1'b1);
        drive(4'b0000, 8'h00, 1'b0);
        drive(4'b1111, 8'h00, 1'b0); expect_a("wrap_rr", 8'h02, 8'h03, 4'b1100, 1'b1);
        drive(4'b0000, 8'h00, 1'b0);

        // Flush overrides a pending request, then arbitration resumes.
        drive(4'b0011, 8'hFF, 1'b1); expect_a("flush",   8'hFF, 8'hFF, 4'b0000, 1'b0);
        drive(4'b0011, 8'h00, 1'b0); expect_a("resume",  8'h00, 8'h01, 4'b0011, 1'b0);
        drive(4'b0000, 8'h00, 1'b0);

        // Asynchronous reset between edges kills a live grant.
        drive(4'b0100, 8'h00, 1'b0); expect_a("pre_rst", 8'h02, 8'hFF, 4'b0100, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async_rst");
        @(negedge clock);
        reset         = 1'b0;
        bus_a.request = 4'b0000;
        bus_b.request = 8'h00;
        sb_a.delete();
        sb_b.delete();
        model_reset();

        // Randomized contention with occasional flush.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) ra[i] = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 8; i++) rb[i] = ($urandom_range(0, 9) < 8);
            fl = ($urandom_range(0, 29) == 0);
            drive(ra, rb, fl);
        end
        @(posedge clock);
        #2;
        check("sb_a.drained", 8'(sb_a.size()), 8'h00);
        check("sb_b.drained", 8'(sb_b.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter REQUESTERS, default 4, number of common-data-bus requesters (2..8); requester i has bus address i.
REQ-002 SHALL have parameter MAX_WAIT, default 7, wait-cycle threshold at which a requester becomes aged.
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports are named clock and reset as on the global bus.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 request  input  REQUESTERS  bit i high = requester i holds a completed result for the bus.
REQ-007 flush  input  1  delete_tag from the global bus; cancels pending arbitration.
REQ-008 select_0  output  8  address of the requester owning data bus 0 this cycle; 8'hFF = idle.
REQ-009 select_1  output  8  address of the requester owning data bus 1 this cycle; 8'hFF = idle.
REQ-010 grant  output  REQUESTERS  bit i high = requester i owns a bus this cycle.
REQ-011 busy  output  1  more eligible requests existed than buses at the last decision.

Function
REQ-012 SHALL register all outputs; requests sampled at edge t produce select/grant visible during cycle t+1, lasting exactly one cycle.
REQ-013 SHALL treat request[i] as eligible only when grant[i] is low in the sampling cycle (one transfer per grant; a held request re-arbitrates after a one-cycle gap).
REQ-014 SHALL choose at most two distinct winners per cycle: first aged requesters (wait count == MAX_WAIT) in ascending index, then the remaining eligible requesters in round-robin order starting at rr_ptr.
REQ-015 SHALL assign the first winner to bus 0 and the second to bus 1; a single winner always takes bus 0, and select_1 = 8'hFF.
REQ-016 SHALL drive grant[i] = 1 iff select_0 == i or select_1 == i; a requester never appears on both buses.
REQ-017 SHALL update rr_ptr to (index of last round-robin winner + 1) mod REQUESTERS; aged winners do not move rr_ptr; unchanged when there are no round-robin winners.
REQ-018 SHALL keep a 3-bit-minimum wait counter per requester: increments (saturating at MAX_WAIT) when eligible and not chosen; clears when chosen or request low.
REQ-019 SHALL set busy at t+1 when eligible count at t exceeds 2, else clear it.
REQ-020 SHALL, when flush is high at edge t: drive both selects 8'hFF and grant 0 in cycle t+1, clear all wait counters and busy, hold rr_ptr; flush overrides any request.
REQ-021 SHALL wrap rr_ptr from REQUESTERS-1 to 0 without skipping requester 0.
REQ-022 SHALL produce no grants and idle selects when no request is eligible.

Reset
REQ-023 SHALL, while reset is high, asynchronously force select_0 = select_1 = 8'hFF, grant = 0, busy = 0, rr_ptr = 0, all wait counters = 0.
REQ-024 SHALL begin arbitration on the first clock edge after reset deasserts; reset mid-grant terminates the grant immediately.

Verification
REQ-025 Reset, then request = 4'b0001 held -> cycle 1: select_0 = 0, grant = 0001; cycle 2: idle (gap); cycle 3: select_0 = 0 again.
REQ-026 request = 4'b1111 held, rr_ptr = 0 -> grants {0,1}, gap-excluded, then {2,3}, then {0,1}; busy = 1 on the first decision.
REQ-027 request = 4'b1110 with rr_ptr = 3 -> select_0 = 3, select_1 = 1; rr_ptr becomes 2 (wrap-around).
REQ-028 requester 3 held while 0,1,2 continuously re-request with rr_ptr biased away -> requester 3 granted on bus 0 no later than the cycle after its counter reaches 7.
REQ-029 request = 4'b0011 with flush pulsed in the same cycle -> next cycle both selects 8'hFF, grant = 0; the following cycle resumes with select_0 = 0, select_1 = 1.
REQ-030 reset asserted asynchronously between edges while grant = 0100 -> grant = 0 and selects 8'hFF before the next edge.
